// File: rtl/wb_queue_if.sv
// Bus bundle for the writeback queue: producer handshakes, forwarding lookup,
// register-file write port and occupancy status.
interface wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic          w_en3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] w_data3;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // queue side
    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
               rd_addr1, rd_addr2,
        output ld_ready, alu_ready, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
               w_en3, addr3, w_data3, count, full, empty
    );

    // producer / decode / register-file side
    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
               rd_addr1, rd_addr2,
        input  ld_ready, alu_ready, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
               w_en3, addr3, w_data3, count, full, empty
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into an in-order FIFO, retires
// one entry per cycle to the register file, and forwards pending writes.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_queue_if.slave      bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    logic [AW-1:0]    ent_rd_r   [DEPTH];
    logic [DW-1:0]    ent_data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic             empty_s;
    logic             ld_ready_s;
    logic             alu_ready_s;
    logic             ld_push_s;
    logic             alu_push_s;
    logic             pop_s;
    logic [1:0]       push_cnt_s;
    logic [PW-1:0]    alu_slot_s;
    logic [DW:0]      fwd1_s;
    logic [DW:0]      fwd2_s;

    // Youngest-wins lookup: walk valid entries oldest to youngest so later
    // matches override earlier ones. Register 0 never hits. Result is {hit, data}.
    function automatic logic [DW:0] fwd_lookup(
        input logic [AW-1:0]    addr,
        input logic [PW-1:0]    head,
        input logic [DEPTH-1:0] valid
    );
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        logic          match;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx   = head + PW'(i);
            match = valid[idx] && (ent_rd_r[idx] == addr) && (addr != '0);
            hit   = hit | match;
            data  = match ? ent_data_r[idx] : data;
        end
        return {hit, data};
    endfunction

    // Handshake and push/pop decode; ready ignores the same-cycle pop.
    always_comb begin
        empty_s     = (count_r == '0);
        ld_ready_s  = (count_r <= DEPTH_M1);
        if (bus.ld_valid) begin
            alu_ready_s = (count_r <= DEPTH_M2);
        end else begin
            alu_ready_s = (count_r <= DEPTH_M1);
        end
        ld_push_s   = bus.ld_valid  && ld_ready_s  && (bus.ld_rd  != '0);
        alu_push_s  = bus.alu_valid && alu_ready_s && (bus.alu_rd != '0);
        pop_s       = !empty_s;
        push_cnt_s  = {1'b0, ld_push_s} + {1'b0, alu_push_s};
        if (ld_push_s) begin
            alu_slot_s = tail_r + PW'(1);
        end else begin
            alu_slot_s = tail_r;
        end
    end

    // Forwarding for both decode read ports.
    always_comb begin
        fwd1_s = fwd_lookup(bus.rd_addr1, head_r, valid_r);
        fwd2_s = fwd_lookup(bus.rd_addr2, head_r, valid_r);
    end

    // FIFO state: pop head, then load entry (older) then ALU entry (younger).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (ld_push_s) begin
                ent_rd_r[tail_r]   <= bus.ld_rd;
                ent_data_r[tail_r] <= bus.ld_data;
                valid_r[tail_r]    <= 1'b1;
            end
            if (alu_push_s) begin
                ent_rd_r[alu_slot_s]   <= bus.alu_rd;
                ent_data_r[alu_slot_s] <= bus.alu_data;
                valid_r[alu_slot_s]    <= 1'b1;
            end
            head_r  <= head_r + PW'(pop_s);
            tail_r  <= tail_r + PW'(push_cnt_s);
            count_r <= count_r + CW'(push_cnt_s) - CW'(pop_s);
        end
    end

    // Write enable is masked during reset so a flushed head never lands.
    assign bus.w_en3     = pop_s && rst_n;
    assign bus.addr3     = empty_s ? '0 : ent_rd_r[head_r];
    assign bus.w_data3   = empty_s ? '0 : ent_data_r[head_r];
    assign bus.ld_ready  = ld_ready_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.fwd_hit1  = fwd1_s[DW];
    assign bus.fwd_data1 = fwd1_s[DW-1:0];
    assign bus.fwd_hit2  = fwd2_s[DW];
    assign bus.fwd_data2 = fwd2_s[DW-1:0];
    assign bus.count     = count_r;
    assign bus.full      = (count_r == DEPTH_C);
    assign bus.empty     = empty_s;

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4) with a small in-order
// scoreboard for the sustained-traffic phase.
module tb_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   mcount;
    logic [DW-1:0] sb[$];

    wb_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ld;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
    endtask

    // One modelled cycle: check readies/occupancy/head against the scoreboard, then clock.
    task automatic model_cycle(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                               input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        logic er_ld;
        logic er_alu;
        drive(lv, lrd, ld, av, ard, ad);
        #1;
        er_ld  = (mcount <= DEPTH - 1);
        er_alu = lv ? (mcount <= DEPTH - 2) : (mcount <= DEPTH - 1);
        check("bp_ld_ready", bus.ld_ready, er_ld);
        check("bp_alu_ready", bus.alu_ready, er_alu);
        check("bp_count", bus.count, mcount);
        check("bp_full", bus.full, mcount == DEPTH);
        check("bp_w_en3", bus.w_en3, mcount != 0);
        if (mcount != 0) begin
            check("bp_w_data3", bus.w_data3, sb[0]);
            void'(sb.pop_front());
        end
        if (lv && er_ld && lrd != '0) sb.push_back(ld);
        if (av && er_alu && ard != '0) sb.push_back(ad);
        mcount = sb.size();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        total  = 0;
        bad    = 0;
        mcount = 0;
        rst_n  = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_count", bus.count, 3'd0);
        check("rst_w_en3", bus.w_en3, 1'b0);
        check("rst_ld_ready", bus.ld_ready, 1'b1);
        check("rst_alu_ready", bus.alu_ready, 1'b1);
        check("rst_fwd_hit1", bus.fwd_hit1, 1'b0);
        check("rst_addr3", bus.addr3, 5'd0);
        check("rst_w_data3", bus.w_data3, 32'h0);
        tick();

        // single ALU write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_00AA);
        #1;
        check("one_alu_ready", bus.alu_ready, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.rd_addr1 = 5'd3;
        #1;
        check("one_w_en3", bus.w_en3, 1'b1);
        check("one_addr3", bus.addr3, 5'd3);
        check("one_w_data3", bus.w_data3, 32'hAA);
        check("one_fwd_hit1", bus.fwd_hit1, 1'b1);
        check("one_fwd_data1", bus.fwd_data1, 32'hAA);
        check("one_count", bus.count, 3'd1);
        tick();
        check("one_empty", bus.empty, 1'b1);
        check("one_w_en3_off", bus.w_en3, 1'b0);
        check("one_fwd_gone", bus.fwd_hit1, 1'b0);

        // dual push to the same register from empty
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        #1;
        check("dual_ld_ready", bus.ld_ready, 1'b1);
        check("dual_alu_ready", bus.alu_ready, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.rd_addr1 = 5'd7;
        #1;
        check("dual_count", bus.count, 3'd2);
        check("dual_fwd_hit1", bus.fwd_hit1, 1'b1);
        check("dual_fwd_young", bus.fwd_data1, 32'h22);
        check("dual_wr0_addr", bus.addr3, 5'd7);
        check("dual_wr0_data", bus.w_data3, 32'h11);
        tick();
        check("dual_count1", bus.count, 3'd1);
        check("dual_wr1_data", bus.w_data3, 32'h22);
        check("dual_fwd_left", bus.fwd_data1, 32'h22);
        tick();
        check("dual_empty", bus.empty, 1'b1);

        // sustained traffic: occupancy saturates at DEPTH-1 because the head drains
        mcount = 0;
        for (int k = 0; k < 8; k++) begin
            model_cycle(1'b1, AW'(k + 1), 32'h100 + k, 1'b1, AW'(k + 10), 32'h200 + k);
        end
        model_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h300);
        for (int k = 0; k < 8 && mcount != 0; k++) begin
            model_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
        check("bp_drained", bus.empty, 1'b1);

        // x0 writes complete the handshake but are dropped
        bus.rd_addr2 = 5'd0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        #1;
        check("x0_alu_ready", bus.alu_ready, 1'b1);
        check("x0_fwd_hit2_in", bus.fwd_hit2, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_count", bus.count, 3'd0);
        check("x0_w_en3", bus.w_en3, 1'b0);
        check("x0_fwd_hit2", bus.fwd_hit2, 1'b0);
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 32'hDEAD);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_mix_count", bus.count, 3'd1);
        check("x0_mix_data", bus.w_data3, 32'h55);
        check("x0_mix_fwd2", bus.fwd_hit2, 1'b0);
        tick();

        // fill to 3, check two-port forwarding, then reset mid-operation
        drive(1'b1, 5'd4, 32'h41, 1'b1, 5'd6, 32'h61);
        tick();
        drive(1'b1, 5'd6, 32'h62, 1'b1, 5'd4, 32'h42);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.rd_addr1 = 5'd6;
        bus.rd_addr2 = 5'd4;
        #1;
        check("rr_count3", bus.count, 3'd3);
        check("rr_head", bus.w_data3, 32'h61);
        check("rr_fwd1", bus.fwd_data1, 32'h62);
        check("rr_fwd2", bus.fwd_data2, 32'h42);
        rst_n = 1'b0;
        #1;
        check("rr_no_write", bus.w_en3, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rr_count0", bus.count, 3'd0);
        check("rr_w_en3", bus.w_en3, 1'b0);
        check("rr_fwd_hit1", bus.fwd_hit1, 1'b0);
        check("rr_fwd_hit2", bus.fwd_hit2, 1'b0);
        tick();
        check("rr_quiet", bus.w_en3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
